// File: rtl/pcie_sniffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcie_sniffer_pkg
// Description : Shared definitions for the PCIe PTM sniffer capture path:
//               K-symbol codes, capture FSM state encoding, capture FIFO
//               entry layout and a lane symbol-match helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pcie_sniffer_pkg;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SKIP    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // Entry layout at the default widths. The top level declares the same
  // field order sized by its own parameters.
  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  ctl;
    logic [63:0] ts;
    logic        last;
  } cap_entry_t;

  // True when a byte lane carries the given K-symbol.
  function automatic logic is_sym(input logic [7:0] lane_byte,
                                  input logic       lane_k,
                                  input logic [7:0] sym);
    return lane_k && (lane_byte == sym);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_sniffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pcie_sniffer_fifo
// Description : Synchronous FIFO, one push and one pop per cycle. The read
//               word is taken straight from the storage flops so it holds
//               while the head entry is not popped.
// Ports       : clk, rst_n          - clock, async active-low reset
//               push, wdata         - write side (never blocked)
//               pop                 - read strobe, ignored when empty
//               rdata, valid        - head entry and non-empty flag
//               free_count          - DEPTH minus current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_sniffer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   free_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_pop;

  assign do_pop = pop && valid;

  always_comb begin
    count_nxt = count;
    if (push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (!push && do_pop) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      valid <= (count_nxt != '0);
    end
  end

  assign rdata      = mem[rd_ptr];
  assign free_count = DEPTH_C - count;

endmodule
`default_nettype wire

// File: rtl/pcie_ptm_sniffer_capture.sv
`default_nettype none
// ============================================================================
// Module      : pcie_ptm_sniffer_capture
// Description : PIPE RX tap. Forwards RX data/ctl through PIPE_STAGES
//               registers and, in parallel, captures STP..END/EDB framed
//               words with their STP timestamp into a capture FIFO.
// Ports       : clk_in, rst_n_in           - clock, async active-low reset
//               rx_data_in, rx_ctl_in      - PIPE RX word and K flags
//               clk_out, rst_n_out         - direct pass-through
//               rx_data_out, rx_ctl_out    - RX word delayed PIPE_STAGES
//               match_en, timestamp_in     - capture enable, free-run time
//               cap_valid/ready/data/ctl/ts/last - capture stream
//               pkt_count, drop_count      - captured / skipped TLPs
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_ptm_sniffer_capture
  import pcie_sniffer_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int CTL_W         = DATA_W / 8,
  parameter int PIPE_STAGES   = 1,
  parameter int CAPTURE_DEPTH = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int TS_W          = 64
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [DATA_W-1:0] rx_data_in,
  input  logic [CTL_W-1:0]  rx_ctl_in,
  output logic              rst_n_out,
  output logic              clk_out,
  output logic [DATA_W-1:0] rx_data_out,
  output logic [CTL_W-1:0]  rx_ctl_out,
  input  logic              match_en,
  input  logic [TS_W-1:0]   timestamp_in,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic [DATA_W-1:0] cap_data,
  output logic [CTL_W-1:0]  cap_ctl,
  output logic [TS_W-1:0]   cap_ts,
  output logic              cap_last,
  output logic [15:0]       pkt_count,
  output logic [15:0]       drop_count
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW  = $clog2(CAPTURE_DEPTH + 1);
  localparam logic [FCW-1:0] CAP_SPACE = FCW'(CAPTURE_DEPTH);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(CAPTURE_DEPTH - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTL_W-1:0]  ctl;
    logic [TS_W-1:0]   ts;
    logic              last;
  } entry_t;

  assign clk_out   = clk_in;
  assign rst_n_out = rst_n_in;

  // Pass-through register chain
  generate
    if (PIPE_STAGES == 0) begin : g_pipe_bypass
      assign rx_data_out = rx_data_in;
      assign rx_ctl_out  = rx_ctl_in;
    end else begin : g_pipe_regs
      logic [DATA_W-1:0] data_q [PIPE_STAGES];
      logic [CTL_W-1:0]  ctl_q  [PIPE_STAGES];
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          for (int s = 0; s < PIPE_STAGES; s++) begin
            data_q[s] <= '0;
            ctl_q[s]  <= '0;
          end
        end else begin
          data_q[0] <= rx_data_in;
          ctl_q[0]  <= rx_ctl_in;
          for (int s = 1; s < PIPE_STAGES; s++) begin
            data_q[s] <= data_q[s-1];
            ctl_q[s]  <= ctl_q[s-1];
          end
        end
      end
      assign rx_data_out = data_q[PIPE_STAGES-1];
      assign rx_ctl_out  = ctl_q[PIPE_STAGES-1];
    end
  endgenerate

  // Decode stage s0, with the timestamp sample that arrived alongside it
  logic [DATA_W-1:0] s0_data;
  logic [CTL_W-1:0]  s0_ctl;
  logic [TS_W-1:0]   s0_ts;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s0_data <= '0;
      s0_ctl  <= '0;
      s0_ts   <= '0;
    end else begin
      s0_data <= rx_data_in;
      s0_ctl  <= rx_ctl_in;
      s0_ts   <= timestamp_in;
    end
  end

  // Lane decode. term_after_stp flags an END/EDB in a lane above the first
  // STP lane, i.e. a TLP that both starts and ends in this word.
  logic stp_any;
  logic term_any;
  logic term_after_stp;

  always_comb begin
    stp_any        = 1'b0;
    term_any       = 1'b0;
    term_after_stp = 1'b0;
    for (int i = 0; i < CTL_W; i++) begin
      if (is_sym(s0_data[8*i +: 8], s0_ctl[i], K_END) ||
          is_sym(s0_data[8*i +: 8], s0_ctl[i], K_EDB)) begin
        term_any = 1'b1;
        if (stp_any) begin
          term_after_stp = 1'b1;
        end
      end
      if (is_sym(s0_data[8*i +: 8], s0_ctl[i], K_STP)) begin
        stp_any = 1'b1;
      end
    end
  end

  // Capture FSM
  state_t          state;
  state_t          state_nxt;
  logic [BW-1:0]   beat_cnt;
  logic [TS_W-1:0] ts_hold;
  logic [FCW-1:0]  free_count;
  logic            space_ok;
  logic            push;
  logic            push_last;
  logic [TS_W-1:0] push_ts;
  logic            start;
  logic            pkt_inc;
  logic            drop_inc;

  // Occupancy before this cycle's pop: never lets a TLP start that could
  // overflow the FIFO partway through.
  assign space_ok = (free_count >= CAP_SPACE);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_last = 1'b0;
    push_ts   = ts_hold;
    start     = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (stp_any && match_en) begin
          if (space_ok) begin
            push    = 1'b1;
            push_ts = s0_ts;
            start   = 1'b1;
            if (term_after_stp || (CAPTURE_DEPTH == 1)) begin
              push_last = 1'b1;
              pkt_inc   = 1'b1;
              state_nxt = term_after_stp ? ST_IDLE : ST_DRAIN;
            end else begin
              state_nxt = ST_CAPTURE;
            end
          end else begin
            drop_inc = 1'b1;
            if (!term_after_stp) begin
              state_nxt = ST_SKIP;
            end
          end
        end
      end
      ST_CAPTURE: begin
        push = 1'b1;
        if (term_any) begin
          push_last = 1'b1;
          pkt_inc   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (beat_cnt == LAST_BEAT) begin
          push_last = 1'b1;
          pkt_inc   = 1'b1;
          state_nxt = ST_DRAIN;
        end
      end
      ST_SKIP, ST_DRAIN: begin
        if (term_any) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= ST_IDLE;
      beat_cnt   <= '0;
      ts_hold    <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        beat_cnt <= BW'(1);
        ts_hold  <= s0_ts;
      end else if (push) begin
        beat_cnt <= beat_cnt + BW'(1);
      end
      if (pkt_inc) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (drop_inc && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Capture FIFO
  entry_t wr_entry;
  entry_t rd_entry;

  assign wr_entry = '{data: s0_data, ctl: s0_ctl, ts: push_ts, last: push_last};

  pcie_sniffer_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .push       (push),
    .wdata      (wr_entry),
    .pop        (cap_ready),
    .rdata      (rd_entry),
    .valid      (cap_valid),
    .free_count (free_count)
  );

  assign cap_data = rd_entry.data;
  assign cap_ctl  = rd_entry.ctl;
  assign cap_ts   = rd_entry.ts;
  assign cap_last = rd_entry.last;

endmodule
`default_nettype wire

// File: doc/pcie_ptm_sniffer_capture.md
# pcie_ptm_sniffer_capture

Parametrised successor of the PTM sniffer tap on the PCIe PIPE receive path. It forwards RX data and control to the PCIe core through a configurable register pipeline. In parallel it detects TLP framing (STP … END/EDB) and captures framed words, with a timestamp taken at STP, into a small FIFO. Firmware drains that FIFO to find PTM Request/Response TLPs and their arrival times.

## Interface
Parameters:
- DATA_W, 16: RX data width; must be a multiple of 8.
- CTL_W, DATA_W/8: K-symbol flags, one per byte lane.
- PIPE_STAGES, 1: pass-through register stages, 0..4. A value of 0 is a combinational pass-through.
- CAPTURE_DEPTH, 8: maximum words captured per TLP.
- FIFO_DEPTH, 16: capture FIFO entries. Must be a power of 2 and ≥ CAPTURE_DEPTH.
- TS_W, 64: timestamp width.

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - clk_in  in  1  PIPE RX clock; the only clock.
  - rst_n_in  in  1  asynchronous, active-low reset; release is synchronised externally.
- Pass-through path:
  - rx_data_in  in  DATA_W  PIPE RX data; byte lane i = bits [8i+7:8i].
  - rx_ctl_in  in  CTL_W  bit i set = lane i carries a K-symbol.
  - rst_n_out, clk_out  out  1  direct pass-through of rst_n_in and clk_in.
  - rx_data_out, rx_ctl_out  out  DATA_W/CTL_W  inputs delayed by PIPE_STAGES.
- Capture control:
  - match_en  in  1  enables starting new captures.
  - timestamp_in  in  TS_W  free-running time, sampled at STP.
- Capture stream:
  - cap_valid  out  1  capture stream valid.
  - cap_ready  in  1  capture stream ready.
  - cap_data  out  DATA_W  captured word.
  - cap_ctl  out  CTL_W  K-flags of the captured word.
  - cap_ts  out  TS_W  STP timestamp; repeated on every beat of the TLP.
  - cap_last  out  1  final beat of the TLP.
- Status:
  - pkt_count  out  16  TLPs captured; wraps.
  - drop_count  out  16  TLPs skipped for lack of space; saturates at 16'hFFFF.

## Operation
- Pass-through: a register chain of PIPE_STAGES stages. On reset, the register contents are 0.
- Input word is registered into stage s0 every cycle. The FSM decodes s0.
- Symbol decode, per lane: a lane is a K-symbol when its ctl bit is set.
  - STP = 8'hFB.
  - END = 8'hFD.
  - EDB = 8'hFE.
- FSM states: IDLE, CAPTURE, SKIP, DRAIN.
- IDLE:
  - STP in any lane and match_en=1 and FIFO free entries ≥ CAPTURE_DEPTH:
    - latch timestamp_in (the sample aligned with s0);
    - push the word;
    - if END/EDB is in a higher lane of the same word, push it with last=1 and stay IDLE;
    - otherwise go to CAPTURE.
  - STP with insufficient space: drop_count++ and go to SKIP.
  - STP with match_en=0: ignore.
- CAPTURE:
  - push every word;
  - a word containing END or EDB is pushed with last=1, pkt_count++, go to IDLE;
  - the CAPTURE_DEPTH-th word is pushed with last=1, pkt_count++, go to DRAIN;
  - an STP seen in CAPTURE is treated as data.
- SKIP/DRAIN: no pushes; return to IDLE on END/EDB. The word carrying END/EDB cannot start a new capture.
- match_en falling mid-TLP does not abort the TLP in progress.
- FIFO:
  - the space check at STP guarantees no overflow mid-TLP;
  - writes are never blocked;
  - reads happen on cap_valid && cap_ready.
- Reset mid-TLP:
  - FSM goes to IDLE;
  - FIFO is emptied;
  - counters go to 0;
  - the partial TLP is lost;
  - the first capture after reset requires a fresh STP.

## Timing
- rx_*_out lag rx_*_in by exactly PIPE_STAGES cycles.
- Capture latency: an input word at cycle t is pushed at the edge ending t+1. With an empty FIFO, cap_valid is high in cycle t+2.
- The FIFO accepts one push and one pop per cycle simultaneously.
- The free-space check uses the occupancy before the current cycle's pop, which is conservative.
- cap_* outputs are registered and hold stable while cap_valid=1 and cap_ready=0.
- Reset values:
  - cap_valid = 0, cap_last = 0;
  - cap_data = 0, cap_ctl = 0, cap_ts = 0;
  - pkt_count = 0, drop_count = 0;
  - FSM in IDLE.

## Structure
- pcie_sniffer_pkg holds:
  - K-symbol constants K_STP, K_END, K_EDB;
  - the state enum;
  - the FIFO entry struct {data, ctl, ts, last}.
- One sub-module, pcie_sniffer_fifo:
  - parametrised synchronous FIFO (width, depth);
  - exposes free_count, push, pop, valid.
- The top level holds the pipeline chain, lane decode, FSM, and counters.

## Test plan
- PIPE_STAGES=2 with random data: rx_data_out equals rx_data_in delayed by 2 cycles. PIPE_STAGES=0 gives combinational equality.
- Single TLP STP(lane0)+3 data+END(lane1), timestamp=100 at STP, cap_ready=1: 5 beats out, cap_ts=100 on all, cap_last only on beat 5, pkt_count=1, first cap_valid 2 cycles after STP.
- 12-word TLP with CAPTURE_DEPTH=8: 8 beats, last on beat 8, remainder dropped, next STP captured normally.
- cap_ready=0, FIFO_DEPTH=16, three 8-word TLPs: first two captured (16 entries), third counted (drop_count=1) with no corruption; after draining, a fourth is captured.
- STP with END in a higher lane of the same word: a single beat with cap_last=1.
- Reset asserted mid-CAPTURE: cap_valid=0 immediately; after release, a trailing END is ignored and the next STP is captured cleanly.
